// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch front end: bus widths,
// chip-enable levels, fetch sequencer states and an address helper.
package fetch_ctrl_pkg;

    localparam int          INST_ADDR_W  = 32;
    localparam int          INST_PAIR_W  = 64;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [31:0] PAIR_BYTES   = 32'd8;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        IF_RESET = 2'd0,
        IF_FETCH = 2'd1,
        IF_HOLD  = 2'd2,
        IF_DRAIN = 2'd3
    } if_state_e;

    // Fetches are always whole pairs, so redirect targets are forced
    // down to an 8-byte boundary.
    function automatic logic [INST_ADDR_W-1:0] align_pair(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/fetch_ctrl_out_buf.sv
// Single-entry valid/ready output register holding one fetched pair,
// its address and per-slot valid bits for the ID stage.
module fetch_ctrl_out_buf
    import fetch_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic                   ready,
    input  logic [INST_ADDR_W-1:0] in_pc,
    input  logic [INST_PAIR_W-1:0] in_inst,
    input  logic [1:0]             in_slot_valid,
    output logic                   valid,
    output logic [INST_ADDR_W-1:0] out_pc,
    output logic [INST_PAIR_W-1:0] out_inst,
    output logic [1:0]             out_slot_valid
);

    // Redirect clears beat a new load, which beats an ordinary drain, so a
    // pair fetched before a redirect can never reach ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid          <= 1'b0;
            out_pc         <= ZERO_WORD;
            out_inst       <= '0;
            out_slot_valid <= 2'b00;
        end else if (clear) begin
            valid          <= 1'b0;
            out_slot_valid <= 2'b00;
        end else if (load) begin
            valid          <= 1'b1;
            out_pc         <= in_pc;
            out_inst       <= in_inst;
            out_slot_valid <= in_slot_valid;
        end else if (valid && ready) begin
            valid          <= 1'b0;
            out_slot_valid <= 2'b00;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one 8-byte pair fetch per
// request, hands pairs to ID, and handles branch/exception redirects,
// including draining a response still in flight when a redirect lands.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag,
    input  logic [INST_ADDR_W-1:0] branch_target,
    input  logic                   mem_ack,
    input  logic [INST_PAIR_W-1:0] mem_rdata,
    input  logic                   id_ready,
    output logic [INST_ADDR_W-1:0] pc,
    output logic                   ce,
    output logic                   mem_req,
    output logic [INST_ADDR_W-1:0] mem_addr,
    output logic                   if_valid,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_PAIR_W-1:0] if_inst,
    output logic [1:0]             if_slot_valid,
    output logic                   addr_err
);

    if_state_e              state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [INST_ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic                   skip_q, skip_d;
    logic                   addr_err_q, addr_err_d;
    logic                   buf_load, buf_clear;
    logic                   redirect;
    logic [INST_ADDR_W-1:0] target;

    assign redirect = flush | branch_flag;
    assign target   = flush ? new_pc : branch_target;
    assign pc       = pc_q;
    assign addr_err = addr_err_q;

    // State, PC, in-flight address, slot-skip flag and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IF_RESET;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            skip_q       <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            skip_q       <= skip_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // Next-state and memory-side outputs. An ack that arrives while the
    // output buffer is full and not draining is dropped without advancing
    // the PC; the pair is simply refetched after leaving HOLD.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        skip_d       = skip_q;
        addr_err_d   = 1'b0;
        ce           = CHIP_ENABLE;
        mem_req      = 1'b0;
        mem_addr     = pc_q;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;

        if (state_q != IF_RESET && redirect) begin
            pc_d       = align_pair(target);
            skip_d     = target[2];
            addr_err_d = |target[1:0];
            buf_clear  = 1'b1;
        end

        case (state_q)
            IF_RESET: begin
                ce      = CHIP_DISABLE;
                state_d = IF_FETCH;
            end
            IF_FETCH: begin
                mem_req = 1'b1;
                if (redirect) begin
                    if (!mem_ack) begin
                        state_d      = IF_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (mem_ack) begin
                    if (!if_valid || id_ready) begin
                        buf_load = 1'b1;
                        skip_d   = 1'b0;
                        pc_d     = pc_q + PAIR_BYTES;
                    end else begin
                        state_d = IF_HOLD;
                    end
                end
            end
            IF_HOLD: begin
                if (redirect || id_ready) begin
                    state_d = IF_FETCH;
                end
            end
            IF_DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = drain_addr_q;
                if (mem_ack) begin
                    state_d = IF_FETCH;
                end
            end
            default: begin
                state_d = IF_RESET;
            end
        endcase
    end

    fetch_ctrl_out_buf u_out_buf (
        .clk            (clk),
        .rst            (rst),
        .load           (buf_load),
        .clear          (buf_clear),
        .ready          (id_ready),
        .in_pc          (pc_q),
        .in_inst        (mem_rdata),
        .in_slot_valid  ({1'b1, ~skip_q}),
        .valid          (if_valid),
        .out_pc         (if_pc),
        .out_inst       (if_inst),
        .out_slot_valid (if_slot_valid)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, back-pressure, redirect during
// an outstanding request, redirect priority, misaligned target, PC wrap and
// reset in the middle of a drain.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata;
    logic        id_ready = 1'b0;
    logic [31:0] pc;
    logic        ce;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [63:0] if_inst;
    logic [1:0]  if_slot_valid;
    logic        addr_err;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    // Instruction memory stand-in: data is a fixed tag xor'ed with the address.
    assign mem_rdata = {32'hB000_0000 ^ mem_addr, 32'hA000_0000 ^ mem_addr};

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .id_ready      (id_ready),
        .pc            (pc),
        .ce            (ce),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_slot_valid (if_slot_valid),
        .addr_err      (addr_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle's inputs, then sample 1 ns after the rising edge.
    task automatic applyStimulus(input logic f, input logic [31:0] npc, input logic b,
                                 input logic [31:0] bt, input logic ack, input logic rdy);
        flush         = f;
        new_pc        = npc;
        branch_flag   = b;
        branch_target = bt;
        mem_ack       = ack;
        id_ready      = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " ce"},        64'(ce),            64'd0);
        checkOutput({tag, " mem_req"},   64'(mem_req),       64'd0);
        checkOutput({tag, " pc"},        64'(pc),            64'h0);
        checkOutput({tag, " if_valid"},  64'(if_valid),      64'd0);
        checkOutput({tag, " slot"},      64'(if_slot_valid), 64'd0);
        checkOutput({tag, " addr_err"},  64'(addr_err),      64'd0);
        checkOutput({tag, " if_pc"},     64'(if_pc),         64'h0);
        checkOutput({tag, " if_inst"},   if_inst,            64'h0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkReset("reset");

        // Reset release and streaming
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("rel ce",       64'(ce),       64'd1);
        checkOutput("rel mem_req",  64'(mem_req),  64'd1);
        checkOutput("rel mem_addr", 64'(mem_addr), 64'h0);
        checkOutput("rel if_valid", 64'(if_valid), 64'd0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("s0 if_valid",  64'(if_valid),      64'd1);
        checkOutput("s0 if_pc",     64'(if_pc),         64'h0);
        checkOutput("s0 if_inst",   if_inst,            64'hB000_0000_A000_0000);
        checkOutput("s0 slot",      64'(if_slot_valid), 64'd3);
        checkOutput("s0 mem_addr",  64'(mem_addr),      64'h8);

        // Back-pressure: ID stalls for three cycles
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("hold mem_req", 64'(mem_req),  64'd0);
        checkOutput("hold if_pc",   64'(if_pc),    64'h0);
        checkOutput("hold valid",   64'(if_valid), 64'd1);
        checkOutput("hold pc",      64'(pc),       64'h8);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("hold2 req",    64'(mem_req),  64'd0);
        checkOutput("hold2 if_pc",  64'(if_pc),    64'h0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("hold3 if_pc",  64'(if_pc),    64'h0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("resume req",   64'(mem_req),  64'd1);
        checkOutput("resume addr",  64'(mem_addr), 64'h8);
        checkOutput("resume valid", 64'(if_valid), 64'd0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("s1 if_pc",     64'(if_pc),    64'h8);
        checkOutput("s1 mem_addr",  64'(mem_addr), 64'h10);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("s2 if_pc",     64'(if_pc),    64'h10);
        checkOutput("s2 mem_addr",  64'(mem_addr), 64'h18);

        // Branch to 0x104 while the 0x18 request is still unacknowledged
        applyStimulus(0, 0, 1, 32'h104, 0, 1);
        checkOutput("drain addr",   64'(mem_addr), 64'h18);
        checkOutput("drain req",    64'(mem_req),  64'd1);
        checkOutput("drain valid",  64'(if_valid), 64'd0);
        checkOutput("drain pc",     64'(pc),       64'h100);
        checkOutput("drain aerr",   64'(addr_err), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("drain2 addr",  64'(mem_addr), 64'h18);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("post addr",    64'(mem_addr), 64'h100);
        checkOutput("post valid",   64'(if_valid), 64'd0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("skip if_pc",   64'(if_pc),         64'h100);
        checkOutput("skip slot",    64'(if_slot_valid), 64'd2);
        checkOutput("skip inst",    if_inst,            64'hB000_0100_A000_0100);
        checkOutput("skip addr",    64'(mem_addr),      64'h108);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("after slot",   64'(if_slot_valid), 64'd3);
        checkOutput("after if_pc",  64'(if_pc),         64'h108);

        // Flush and branch together with a held pair and ID stalled
        applyStimulus(1, 32'h180, 1, 32'h200, 1, 0);
        checkOutput("prio addr",    64'(mem_addr), 64'h180);
        checkOutput("prio valid",   64'(if_valid), 64'd0);
        checkOutput("prio aerr",    64'(addr_err), 64'd0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("prio if_pc",   64'(if_pc),         64'h180);
        checkOutput("prio slot",    64'(if_slot_valid), 64'd3);

        // Misaligned branch target
        applyStimulus(0, 0, 1, 32'h103, 1, 1);
        checkOutput("mis aerr",     64'(addr_err), 64'd1);
        checkOutput("mis addr",     64'(mem_addr), 64'h100);
        checkOutput("mis valid",    64'(if_valid), 64'd0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("mis aerr off", 64'(addr_err),      64'd0);
        checkOutput("mis if_pc",    64'(if_pc),         64'h100);
        checkOutput("mis slot",     64'(if_slot_valid), 64'd3);

        // PC wrap at the top of the address space
        applyStimulus(1, 32'hFFFF_FFF8, 0, 0, 1, 1);
        checkOutput("wrap addr",    64'(mem_addr), 64'hFFFF_FFF8);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("wrap next",    64'(mem_addr), 64'h0);
        checkOutput("wrap if_pc",   64'(if_pc),    64'hFFFF_FFF8);

        // Reset in the middle of a drain
        applyStimulus(0, 0, 1, 32'h40, 0, 1);
        checkOutput("rd addr",      64'(mem_addr), 64'h0);
        checkOutput("rd pc",        64'(pc),       64'h40);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkReset("rst drain");
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("rerel addr",   64'(mem_addr), 64'h0);
        checkOutput("rerel req",    64'(mem_req),  64'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the CPU front end: owns the program counter and chip-enable, issues one 8-byte (two-instruction) fetch per request to instruction memory over a req/ack handshake, and delivers the fetched pair to the ID stage with a valid/ready handshake. Handles branch redirects and exception flushes, including discarding a response that is still outstanding when a redirect arrives. Sits between the instruction ROM/cache port and `if_id`.

## Interface
- `RESET_PC`, `32'h0000_0000`, first fetch address after reset (8-byte aligned)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  exception/eret redirect; highest priority
- `new_pc`  in  32  redirect target for `flush`
- `branch_flag`  in  1  taken-branch redirect from ID
- `branch_target`  in  32  redirect target for `branch_flag`
- `mem_ack`  in  1  memory accepted the request and returns data this cycle
- `mem_rdata`  in  64  {inst1, inst0}; inst0 at addr, inst1 at addr+4
- `id_ready`  in  1  ID accepts the held pair this cycle
- `pc`  out  32  current fetch address (`InstAddrBus`)
- `ce`  out  1  chip enable (`ChipEnable`/`ChipDisable`)
- `mem_req`  out  1  fetch request
- `mem_addr`  out  32  request address, always `pc`, bits[2:0]=0
- `if_valid`  out  1  output pair valid
- `if_pc`  out  32  address of inst0 of the held pair
- `if_inst`  out  64  held instruction pair
- `if_slot_valid`  out  2  per-slot valid; bit0=inst0, bit1=inst1
- `addr_err`  out  1  one-cycle pulse: redirect target had bits[1:0]≠0

## Operation
- States: RESET, FETCH, HOLD, DRAIN.
- RESET (during `rst`): `pc=RESET_PC`, `ce=0`, `mem_req=0`, `if_valid=0`, `if_slot_valid=0`, `addr_err=0`, `if_pc=0`, `if_inst=0`, skip flag=0. Leaves to FETCH on first cycle with `rst=0`.
- FETCH: `ce=1`, `mem_req=1`, `mem_addr=pc`. Request held with stable address until `mem_ack`. On ack: capture `{mem_rdata, pc}` into output regs; slot0 valid unless skip flag set; clear skip; `pc<=pc+8`. If output buffer is free or being drained this cycle (`!if_valid || id_ready`), stay FETCH (back-to-back, one pair/cycle); else go HOLD.
- HOLD: `mem_req=0`; outputs stable until `id_ready`, then clear `if_valid` and return to FETCH.
- Redirect (`flush`, else `branch_flag`), in any non-RESET state: `pc<=target & ~7`; skip flag = `target[2]` (inst0 of first new pair is invalid); `if_valid` cleared next cycle regardless of `id_ready`; `addr_err` pulses if `target[1:0]≠0` (redirect still taken, bits[1:0] dropped). If in FETCH with `mem_ack=0`, go DRAIN; otherwise FETCH.
- DRAIN: `mem_req=1` held with the old address (handshake rule); on `mem_ack` discard data, go FETCH at redirected `pc`. A further redirect in DRAIN only updates `pc`/skip.
- `flush` and `branch_flag` together: `new_pc` wins.
- `rst` mid-request: immediate return to RESET; memory must tolerate request withdrawal on reset.

## Timing
- `rst` deassert at edge N: `ce=1`, `mem_req=1`, `mem_addr=RESET_PC` during cycle N+1.
- Ack in cycle k → `if_valid=1` in k+1; next request address `pc+8` in k+1.
- Redirect sampled in cycle k → `mem_addr=target&~7` (or old addr if DRAIN) in k+1; `if_valid=0` in k+1.
- `pc` wraps modulo 2^32 (0xFFFF_FFF8+8 → 0).
- `if_valid` changes only at edges; never combinationally depends on `id_ready`.

## Structure
- Shared `defines.v`: `ZeroWord`, `ChipEnable/Disable`, `RstEnable`, `InstAddrBus`, add `InstPairBus` (63:0) and state encodings `IF_RESET/FETCH/HOLD/DRAIN`.
- Optional sub-module `if_out_buf`: the single-entry valid/ready output register (inst, pc, slot_valid). Replaces `pc_reg` in `openmips` top.

## Test plan
- Reset release, `mem_ack` tied 1, `id_ready` 1 → addresses 0x0,0x8,0x10… one per cycle; `if_pc` follows one cycle later; `if_slot_valid=2'b11`.
- `id_ready=0` for 3 cycles after first pair → state HOLD, `mem_req=0`, `if_pc=0x0` stable; resumes at 0x8 the cycle after `id_ready=1`.
- `mem_ack` delayed 3 cycles, `branch_flag` with target 0x104 in cycle 1 → `mem_addr` stays 0x0 until ack, data discarded, next request 0x100, delivered `if_slot_valid=2'b10`.
- `flush`(new_pc 0x180) and `branch_flag`(0x200) same cycle → next `mem_addr=0x180`, held pair dropped.
- `branch_target=0x103` → `addr_err` one-cycle pulse, fetch at 0x100, slot0 valid.
- `pc=0xFFFF_FFF8` via flush, ack → next `mem_addr=0x0`; `rst` asserted mid-DRAIN → all outputs at reset values next cycle.
